mod60_ctrl: RTL and testbench

Run/stop/set controller for the MOD-60 two-digit BCD counter datapath (ones digit `led1`, tens digit `led2`). It turns three button inputs into single-cycle advance, clear and load commands for the counter. A prescaler generates the one-second advance rate. In set mode the block holds a shadow value that the user edits one digit at a time and then loads into the counter.

---
 rtl/mod60_pkg.sv | 16 +
 rtl/mod60_ctrl_btn_edge.sv | 18 +
 rtl/mod60_ctrl.sv | 157 +++++++++++++++
 tb/tb_mod60_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mod60_pkg.sv
// rtl/mod60_pkg.sv - shared states, digit limits and widths for the MOD-60 controller
package mod60_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    SET_T = 2'd2,
    SET_O = 2'd3
  } state_t;

  localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(9);

endpackage

// File: rtl/mod60_ctrl_btn_edge.sv
// rtl/mod60_ctrl_btn_edge.sv - rising-edge detector for a synchronized button level
module btn_edge (
  input  logic clki,
  input  logic rs,
  input  logic btn,
  output logic rise
);

  logic prev;

  // Loads the live level even in reset, so a button held through reset release gives no edge.
  always_ff @(posedge clki) begin
    prev <= btn;
  end

  assign rise = rs & btn & ~prev;

endmodule

// File: rtl/mod60_ctrl.sv
// rtl/mod60_ctrl.sv - run/stop/set controller for the MOD-60 BCD counter; blink under MOD60_CTRL_BLINK_EN
module mod60_ctrl
  import mod60_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic               clki,
  input  logic               rs,
  input  logic               btn_ss,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [DIGIT_W-1:0] cnt_ones,
  input  logic [DIGIT_W-1:0] cnt_tens,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               cnt_ld,
  output logic [DIGIT_W-1:0] ld_ones,
  output logic [DIGIT_W-1:0] ld_tens,
  output logic               wrap,
  output logic [1:0]         state,
  output logic               blank_ones,
  output logic               blank_tens
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  state_t             st, st_nxt;
  logic [PW-1:0]      pre, pre_nxt;
  logic [DIGIT_W-1:0] sh_o, sh_o_nxt, sh_t, sh_t_nxt;
  logic               en_nxt, clr_nxt, ld_nxt, wrap_nxt, inc_acc, tick;
  logic               ss_e, mode_e, inc_e;

  btn_edge u_ss   (.clki(clki), .rs(rs), .btn(btn_ss),   .rise(ss_e));
  btn_edge u_mode (.clki(clki), .rs(rs), .btn(btn_mode), .rise(mode_e));
  btn_edge u_inc  (.clki(clki), .rs(rs), .btn(btn_inc),  .rise(inc_e));

  assign tick = (pre == PW'(DIV - 1));

  // Edge priority falls out of the if/else order: ss, then mode, then inc.
  always_comb begin
    st_nxt   = st;
    sh_o_nxt = sh_o;
    sh_t_nxt = sh_t;
    en_nxt   = 1'b0;
    clr_nxt  = 1'b0;
    ld_nxt   = 1'b0;
    wrap_nxt = 1'b0;
    inc_acc  = 1'b0;
    case (st)
      STOP: begin
        if (ss_e) st_nxt = RUN;
        else if (mode_e) begin
          st_nxt   = SET_T;
          sh_t_nxt = cnt_tens;
          sh_o_nxt = cnt_ones;
        end else if (inc_e) clr_nxt = 1'b1;
      end
      RUN: begin
        if (ss_e) st_nxt = STOP;
        else if (tick) begin
          en_nxt   = 1'b1;
          wrap_nxt = (cnt_tens == TENS_MAX) && (cnt_ones == ONES_MAX);
        end
      end
      SET_T: begin
        if (ss_e) begin
          ld_nxt = 1'b1;
          st_nxt = STOP;
        end else if (mode_e) st_nxt = SET_O;
        else if (inc_e) begin
          inc_acc  = 1'b1;
          sh_t_nxt = (sh_t >= TENS_MAX) ? '0 : sh_t + DIGIT_W'(1);
        end
      end
      SET_O: begin
        if (ss_e || mode_e) begin
          ld_nxt = 1'b1;
          st_nxt = STOP;
        end else if (inc_e) begin
          inc_acc  = 1'b1;
          sh_o_nxt = (sh_o >= ONES_MAX) ? '0 : sh_o + DIGIT_W'(1);
        end
      end
      default: st_nxt = STOP;
    endcase
  end

`ifdef MOD60_CTRL_BLINK_EN
  logic ph, ph_nxt;
  logic in_set_nxt;

  assign in_set_nxt = (st_nxt == SET_T) || (st_nxt == SET_O);

  // In SET states the prescaler times half-periods of the blink instead of count advances.
  always_comb begin
    pre_nxt = '0;
    ph_nxt  = 1'b0;
    if (st == RUN && st_nxt == RUN) begin
      pre_nxt = tick ? '0 : pre + PW'(1);
    end else if (in_set_nxt && !(st_nxt != st || inc_acc)) begin
      if (pre == PW'(DIV / 2 - 1)) begin
        ph_nxt = ~ph;
      end else begin
        pre_nxt = pre + PW'(1);
        ph_nxt  = ph;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (!rs) begin
      ph         <= 1'b0;
      blank_ones <= 1'b0;
      blank_tens <= 1'b0;
    end else begin
      ph         <= ph_nxt;
      blank_ones <= (st_nxt == SET_O) & ph_nxt;
      blank_tens <= (st_nxt == SET_T) & ph_nxt;
    end
  end
`else
  always_comb begin
    pre_nxt = '0;
    if (st == RUN && st_nxt == RUN) pre_nxt = tick ? '0 : pre + PW'(1);
  end

  assign blank_ones = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_ff @(posedge clki) begin
    if (!rs) begin
      st      <= STOP;
      pre     <= '0;
      sh_o    <= '0;
      sh_t    <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_ld  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      st      <= st_nxt;
      pre     <= pre_nxt;
      sh_o    <= sh_o_nxt;
      sh_t    <= sh_t_nxt;
      cnt_en  <= en_nxt;
      cnt_clr <= clr_nxt;
      cnt_ld  <= ld_nxt;
      wrap    <= wrap_nxt;
    end
  end

  assign state   = st;
  assign ld_ones = sh_o;
  assign ld_tens = sh_t;

endmodule

// File: tb/tb_mod60_ctrl.sv
// tb/tb_mod60_ctrl.sv - directed self-checking bench for mod60_ctrl at DIV = 4
module tb_mod60_ctrl;

  logic       clki = 1'b0;
  logic       rs, btn_ss, btn_mode, btn_inc;
  logic [3:0] cnt_ones, cnt_tens, ld_ones, ld_tens;
  logic       cnt_en, cnt_clr, cnt_ld, wrap, blank_ones, blank_tens;
  logic [1:0] state;
  int         ncomp = 0;
  int         nerr  = 0;

  mod60_ctrl #(.DIV(4)) dut (
    .clki(clki), .rs(rs), .btn_ss(btn_ss), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cnt_ones(cnt_ones), .cnt_tens(cnt_tens), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_ld(cnt_ld), .ld_ones(ld_ones), .ld_tens(ld_tens), .wrap(wrap), .state(state),
    .blank_ones(blank_ones), .blank_tens(blank_tens)
  );

  always #5 clki = ~clki;

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // outs packs {cnt_en, cnt_clr, cnt_ld, wrap}
  function automatic logic [7:0] outs();
    return {4'd0, cnt_en, cnt_clr, cnt_ld, wrap};
  endfunction

  initial begin
    rs = 1'b0; btn_ss = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cnt_ones = 4'd0; cnt_tens = 4'd0;
    repeat (3) step();
    chk("reset_state", {6'd0, state}, 8'd0);
    chk("reset_outs", outs(), 8'h0);
    chk("reset_shadow", {ld_tens, ld_ones}, 8'h00);
    chk("reset_blank", {6'd0, blank_tens, blank_ones}, 8'd0);

    rs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_ss_state", {6'd0, state}, 8'd0);
      chk("held_ss_outs", outs(), 8'h0);
    end
    btn_ss = 1'b0;
    step();

    cnt_tens = 4'd5; cnt_ones = 4'd9;
    btn_ss = 1'b1;
    step();
    chk("run_entry_state", {6'd0, state}, 8'd1);
    btn_ss = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int q = 0; q < 3; q++) begin
        step();
        chk("run_idle_outs", outs(), 8'h0);
      end
      step();
      chk("run_tick_wrap", outs(), 8'h9);
    end

    cnt_tens = 4'd2; cnt_ones = 4'd7;
    step();
    step();
    step();
    chk("pre_stop_outs", outs(), 8'h0);
    btn_ss = 1'b1;
    step();
    chk("stop_beats_tick_outs", outs(), 8'h0);
    chk("stop_beats_tick_state", {6'd0, state}, 8'd0);
    btn_ss = 1'b0;
    step();
    chk("after_stop_outs", outs(), 8'h0);

    btn_inc = 1'b1;
    step();
    chk("inc_stop_clr", outs(), 8'h4);
    chk("inc_stop_state", {6'd0, state}, 8'd0);
    btn_inc = 1'b0;
    step();
    chk("clr_one_cycle", outs(), 8'h0);
    btn_ss = 1'b1; btn_inc = 1'b1;
    step();
    chk("ss_inc_state", {6'd0, state}, 8'd1);
    chk("ss_inc_no_clr", outs(), 8'h0);
    btn_ss = 1'b0; btn_inc = 1'b0;
    step();
    btn_inc = 1'b1;
    step();
    chk("inc_run_outs", outs(), 8'h0);
    chk("inc_run_state", {6'd0, state}, 8'd1);
    btn_inc = 1'b0; btn_ss = 1'b1;
    step();
    chk("run_to_stop", {6'd0, state}, 8'd0);
    btn_ss = 1'b0;
    step();

    btn_mode = 1'b1;
    step();
    chk("set_t_state", {6'd0, state}, 8'd2);
    chk("capture", {ld_tens, ld_ones}, 8'h27);
    btn_mode = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_t;
      exp_t = (i == 3) ? 4'd0 : 4'(3 + i);
      btn_inc = 1'b1;
      step();
      chk("tens_inc", {4'd0, ld_tens}, {4'd0, exp_t});
      btn_inc = 1'b0;
      step();
    end
    btn_mode = 1'b1;
    step();
    chk("set_o_state", {6'd0, state}, 8'd3);
    btn_mode = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] exp_o;
      exp_o = (i == 2) ? 4'd0 : 4'(8 + i);
      btn_inc = 1'b1;
      step();
      chk("ones_inc", {4'd0, ld_ones}, {4'd0, exp_o});
      btn_inc = 1'b0;
      step();
    end
    btn_mode = 1'b1;
    step();
    chk("load_pulse", outs(), 8'h2);
    chk("load_value", {ld_tens, ld_ones}, 8'h00);
    chk("load_state", {6'd0, state}, 8'd0);
    btn_mode = 1'b0;
    step();
    chk("load_one_cycle", outs(), 8'h0);

    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc = 1'b1;
    step();
    chk("mid_set_ones", {ld_tens, ld_ones}, 8'h28);
    btn_inc = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
`ifdef MOD60_CTRL_BLINK_EN
      logic [1:0] exp_b;
      exp_b = (i < 2) ? 2'b01 : 2'b00;
`else
      logic [1:0] exp_b;
      exp_b = 2'b00;
`endif
      step();
      chk("blink_set_o", {6'd0, blank_tens, blank_ones}, {6'd0, exp_b});
    end
    rs = 1'b0;
    step();
    chk("rst_mid_state", {6'd0, state}, 8'd0);
    chk("rst_mid_shadow", {ld_tens, ld_ones}, 8'h00);
    chk("rst_mid_outs", outs(), 8'h0);
    rs = 1'b1;
    step();
    chk("post_rst_outs", outs(), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
    $finish;
  end

endmodule
